line_window_3x3: RTL and testbench

//   Consumes a raster pixel stream (row-major, IMG_WIDTH x IMG_HEIGHT) and emits

---
 rtl/line_window_3x3.sv | 125 ++++++++++++
 tb/tb_line_window_3x3.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/line_window_3x3.sv
// 3x3 sliding-window generator for a raster pixel stream. Two line delays are kept as
// column-addressed buffers feeding a 3x3 tap array; windows never straddle line or frame edges.
module line_window_3x3 #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned IMG_WIDTH  = 640,
   parameter int unsigned IMG_HEIGHT = 480
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [DATA_WIDTH-1:0]   in_pixel,
   output logic                    out_valid,
   output logic [9*DATA_WIDTH-1:0] out_window,
   output logic [15:0]             out_row,
   output logic [15:0]             out_col,
   output logic                    frame_done
);

   localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

   logic [DATA_WIDTH-1:0]   line1_q [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   line1_d [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   line2_q [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   line2_d [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]   tap_q [3][3];
   logic [DATA_WIDTH-1:0]   tap_d [3][3];
   logic [ColW-1:0]         col_q, col_d;
   logic [RowW-1:0]         row_q, row_d;
   logic [9*DATA_WIDTH-1:0] win_q, win_d;
   logic [15:0]             orow_q, orow_d;
   logic [15:0]             ocol_q, ocol_d;
   logic                    valid_q, valid_d;
   logic                    done_q, done_d;
   logic [DATA_WIDTH-1:0]   line1_out, line2_out;

   // A line delay of exactly IMG_WIDTH entries is a buffer addressed by the current column.
   assign line1_out = line1_q[col_q];
   assign line2_out = line2_q[col_q];

   always_comb begin
      line1_d = line1_q;
      line2_d = line2_q;
      tap_d   = tap_q;
      col_d   = col_q;
      row_d   = row_q;
      win_d   = win_q;
      orow_d  = orow_q;
      ocol_d  = ocol_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      if (in_valid) begin
         line1_d[col_q] = in_pixel;
         line2_d[col_q] = line1_out;
         for (int r = 0; r < 3; r++) begin
            tap_d[r][0] = tap_q[r][1];
            tap_d[r][1] = tap_q[r][2];
         end
         tap_d[0][2] = line2_out;
         tap_d[1][2] = line1_out;
         tap_d[2][2] = in_pixel;

         if (col_q == ColLast) begin
            col_d = '0;
            row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end

         // Rows/cols 0 and 1 of each line still hold partial or previous-frame data.
         if (row_q >= RowW'(2) && col_q >= ColW'(2)) begin
            valid_d = 1'b1;
            for (int r = 0; r < 3; r++) begin
               for (int c = 0; c < 3; c++) begin
                  win_d[DATA_WIDTH*(3*r+c) +: DATA_WIDTH] = tap_d[r][c];
               end
            end
            orow_d = 16'(row_q - RowW'(1));
            ocol_d = 16'(col_q - ColW'(1));
         end
         done_d = (row_q == RowLast) && (col_q == ColLast);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(IMG_WIDTH); i++) begin
            line1_q[i] <= '0;
            line2_q[i] <= '0;
         end
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               tap_q[r][c] <= '0;
            end
         end
         col_q   <= '0;
         row_q   <= '0;
         win_q   <= '0;
         orow_q  <= '0;
         ocol_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         line1_q <= line1_d;
         line2_q <= line2_d;
         tap_q   <= tap_d;
         col_q   <= col_d;
         row_q   <= row_d;
         win_q   <= win_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_window = win_q;
   assign out_row    = orow_q;
   assign out_col    = ocol_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 on a 4x4 image with pixel value base + 4*row + col.
module tb_line_window_3x3;
   localparam int DW = 12;
   localparam int W  = 4;
   localparam int H  = 4;

   typedef struct {
      int   k;
      logic exp_valid;
      logic exp_done;
      int   exp_row;
      int   exp_col;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [DW-1:0]   in_pixel;
   logic            out_valid;
   logic [9*DW-1:0] out_window;
   logic [15:0]     out_row;
   logic [15:0]     out_col;
   logic            frame_done;

   int checks   = 0;
   int failures = 0;
   int nwin     = 0;
   int ndone    = 0;
   vec_t tab [0:15];

   always #5 clk = ~clk;

   line_window_3x3 #(
      .DATA_WIDTH(DW),
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_pixel  (in_pixel),
      .out_valid (out_valid),
      .out_window(out_window),
      .out_row   (out_row),
      .out_col   (out_col),
      .frame_done(frame_done)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [9*DW-1:0] win(input int base, input int cr, input int cc);
      logic [9*DW-1:0] w;
      w = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w[DW*(3*r+c) +: DW] = DW'(base + W*(cr-1+r) + (cc-1+c));
         end
      end
      return w;
   endfunction

   // One clock edge with the given inputs; outputs sampled 1ns after the edge.
   task automatic step(input logic r, input logic v, input logic [DW-1:0] p);
      rst      = r;
      in_valid = v;
      in_pixel = p;
      @(posedge clk);
      #1;
      if (out_valid) nwin++;
      if (frame_done) ndone++;
   endtask

   task automatic apply(input vec_t v, input int base, input string tag);
      int r;
      int c;
      r = v.k / W;
      c = v.k % W;
      step(1'b0, 1'b1, DW'(base + W*r + c));
      chk($sformatf("%s k%0d valid", tag, v.k), 128'(out_valid), 128'(v.exp_valid));
      chk($sformatf("%s k%0d done", tag, v.k), 128'(frame_done), 128'(v.exp_done));
      if (v.exp_valid) begin
         chk($sformatf("%s k%0d window", tag, v.k), 128'(out_window),
             128'(win(base, v.exp_row, v.exp_col)));
         chk($sformatf("%s k%0d row", tag, v.k), 128'(out_row), 128'(v.exp_row));
         chk($sformatf("%s k%0d col", tag, v.k), 128'(out_col), 128'(v.exp_col));
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " valid"}, 128'(out_valid), 128'(0));
      chk({tag, " done"}, 128'(frame_done), 128'(0));
      chk({tag, " window"}, 128'(out_window), 128'(0));
      chk({tag, " row"}, 128'(out_row), 128'(0));
      chk({tag, " col"}, 128'(out_col), 128'(0));
   endtask

   initial begin
      tab = '{
         '{0,  1'b0, 1'b0, 0, 0}, '{1,  1'b0, 1'b0, 0, 0},
         '{2,  1'b0, 1'b0, 0, 0}, '{3,  1'b0, 1'b0, 0, 0},
         '{4,  1'b0, 1'b0, 0, 0}, '{5,  1'b0, 1'b0, 0, 0},
         '{6,  1'b0, 1'b0, 0, 0}, '{7,  1'b0, 1'b0, 0, 0},
         '{8,  1'b0, 1'b0, 0, 0}, '{9,  1'b0, 1'b0, 0, 0},
         '{10, 1'b1, 1'b0, 1, 1}, '{11, 1'b1, 1'b0, 1, 2},
         '{12, 1'b0, 1'b0, 0, 0}, '{13, 1'b0, 1'b0, 0, 0},
         '{14, 1'b1, 1'b0, 2, 1}, '{15, 1'b1, 1'b1, 2, 2}
      };

      // Reset state
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      chk_reset_outputs("reset");

      // Test 1: continuous frame
      nwin  = 0;
      ndone = 0;
      for (int i = 0; i < 16; i++) apply(tab[i], 0, "t1");
      chk("t1 windows", 128'(nwin), 128'(4));
      chk("t1 done pulses", 128'(ndone), 128'(1));

      // Test 2: in_valid toggling; idle cycles never produce a window and hold the outputs
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 16; i++) begin
         apply(tab[i], 0, "t2");
         step(1'b0, 1'b0, DW'(12'hABC));
         chk($sformatf("t2 idle%0d valid", i), 128'(out_valid), 128'(0));
         chk($sformatf("t2 idle%0d done", i), 128'(frame_done), 128'(0));
         if (tab[i].exp_valid)
            chk($sformatf("t2 idle%0d hold", i), 128'(out_window),
                128'(win(0, tab[i].exp_row, tab[i].exp_col)));
      end

      // Test 3: partial 0xFFF frame, mid-frame reset, clean restart
      step(1'b1, 1'b0, '0);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, DW'(12'hFFF));
      step(1'b1, 1'b0, '0);
      chk_reset_outputs("t3 after rst");
      nwin = 0;
      for (int i = 0; i < 16; i++) apply(tab[i], 0, "t3");
      chk("t3 windows", 128'(nwin), 128'(4));

      // Test 4: two frames back-to-back, second offset by 100
      step(1'b1, 1'b0, '0);
      nwin  = 0;
      ndone = 0;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 16; i++) apply(tab[i], 100*f, $sformatf("t4 f%0d", f));
      end
      chk("t4 windows", 128'(nwin), 128'(8));
      chk("t4 done pulses", 128'(ndone), 128'(2));

      // Test 5: rst and in_valid together after a window was produced
      step(1'b1, 1'b0, '0);
      for (int i = 0; i <= 10; i++) apply(tab[i], 0, "t5 pre");
      step(1'b1, 1'b1, DW'(12'h123));
      chk_reset_outputs("t5 rst+valid");
      nwin = 0;
      for (int i = 0; i < 16; i++) apply(tab[i], 0, "t5");
      chk("t5 windows", 128'(nwin), 128'(4));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
